// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit:
// FSM states, opcodes, select codes and the ALU-op helper.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_SRA = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_BNE = 4'd7;
    localparam logic [3:0] ALU_LUI = 4'd8;
    localparam logic [3:0] ALU_OR  = 4'd9;

    localparam logic [3:0] EXT_NONE = 4'd0;
    localparam logic [3:0] EXT_I    = 4'd1;
    localparam logic [3:0] EXT_S    = 4'd2;
    localparam logic [3:0] EXT_B    = 4'd3;
    localparam logic [3:0] EXT_J    = 4'd4;
    localparam logic [3:0] EXT_U    = 4'd5;

    localparam logic [1:0] RS_NONE = 2'b00;
    localparam logic [1:0] RS_MEM  = 2'b01;
    localparam logic [1:0] RS_ALU  = 2'b10;
    localparam logic [1:0] RS_PC4  = 2'b11;

    localparam logic [1:0] SRC_RS2 = 2'b00;
    localparam logic [1:0] SRC_IMM = 2'b01;
    localparam logic [1:0] SRC_PC  = 2'b10;

    typedef struct packed {
        logic       j_sel;
        logic [1:0] reg_sel;
        logic [3:0] ext_sel;
        logic [1:0] alu_src;
        logic [3:0] alu_sel;
        logic       width;
    } sel_t;

    // funct3 -> ALU op shared by R and I forms; alt picks sub/sra.
    function automatic logic [3:0] alu_of(input logic [2:0] f3,
                                          input logic alt);
        unique case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode_tbl.sv
// Pure combinational decode of an instruction word into datapath selects.
// Ports: instr in; selects, illegal and class flags (load/store/branch/wb) out.
module ctrl_decode_tbl
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic        j_sel,
    output logic [1:0]  reg_sel,
    output logic [3:0]  ext_sel,
    output logic [1:0]  alu_src,
    output logic [3:0]  alu_sel,
    output logic        width,
    output logic        illegal,
    output logic        is_load,
    output logic        is_store,
    output logic        is_br,
    output logic        is_wb
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_zero;
    logic       f7_alt;
    logic       f3_ok;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign f3            = instr[14:12];
    assign f7            = instr[31:25];
    assign f7_zero       = (f7 == F7_ZERO);
    assign f7_alt        = (f7 == F7_ALT);
    // slt/sltu (010/011) are the only funct3 values outside the subset
    assign f3_ok         = (f3[2:1] != 2'b01);
    assign unused_fields = ^instr[24:15] ^ ^instr[11:7];

    always_comb begin
        j_sel    = 1'b0;
        reg_sel  = RS_NONE;
        ext_sel  = EXT_NONE;
        alu_src  = SRC_RS2;
        alu_sel  = ALU_ADD;
        width    = 1'b0;
        illegal  = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_br    = 1'b0;
        is_wb    = 1'b0;
        unique case (opcode)
            OP_R: begin
                reg_sel = RS_ALU;
                is_wb   = 1'b1;
                alu_sel = alu_of(f3, f7_alt);
                // only add/sub and srl/sra have a funct7 alternate
                if (f3 == 3'b000 || f3 == 3'b101)
                    illegal = !(f7_zero || f7_alt) || !f3_ok;
                else
                    illegal = !f7_zero || !f3_ok;
            end
            OP_I: begin
                reg_sel = RS_ALU;
                ext_sel = EXT_I;
                alu_src = SRC_IMM;
                is_wb   = 1'b1;
                // addi has no alternate; bit 30 is just immediate
                alu_sel = alu_of(f3, f7_alt && f3 == 3'b101);
                if (f3 == 3'b001)
                    illegal = !f7_zero;
                else if (f3 == 3'b101)
                    illegal = !(f7_zero || f7_alt);
                else
                    illegal = !f3_ok;
            end
            OP_LOAD: begin
                reg_sel = RS_MEM;
                ext_sel = EXT_I;
                alu_src = SRC_IMM;
                is_load = 1'b1;
                width   = (f3 == 3'b100);
                illegal = !(f3 == 3'b010 || f3 == 3'b100);
            end
            OP_S: begin
                ext_sel  = EXT_S;
                alu_src  = SRC_IMM;
                is_store = 1'b1;
                width    = (f3 == 3'b000);
                illegal  = !(f3 == 3'b010 || f3 == 3'b000);
            end
            OP_B: begin
                ext_sel = EXT_B;
                alu_sel = ALU_BNE;
                is_br   = 1'b1;
                illegal = (f3 != 3'b001);
            end
            OP_JALR: begin
                j_sel   = 1'b1;
                reg_sel = RS_PC4;
                ext_sel = EXT_I;
                alu_src = SRC_IMM;
                is_wb   = 1'b1;
                illegal = (f3 != 3'b000);
            end
            OP_JAL: begin
                j_sel   = 1'b1;
                reg_sel = RS_PC4;
                ext_sel = EXT_J;
                alu_src = SRC_PC;
                is_wb   = 1'b1;
            end
            OP_LUI: begin
                reg_sel = RS_ALU;
                ext_sel = EXT_U;
                alu_src = SRC_IMM;
                alu_sel = ALU_LUI;
                is_wb   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            is_load  = 1'b0;
            is_store = 1'b0;
            is_br    = 1'b0;
            is_wb    = 1'b0;
        end
    end

endmodule

// File: rtl/ctrl_unit_mc.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with memory timeouts.
// Ports: clk, rst_n, if_ack/instr, dm_ack, br_taken in; requests, strobes, selects out.
module ctrl_unit_mc
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_ack,
    input  logic [31:0] instr,
    input  logic        dm_ack,
    input  logic        br_taken,
    output logic        if_req,
    output logic        ir_we,
    output logic        dm_req,
    output logic        ws_en,
    output logic        w_en,
    output logic        pc_we,
    output logic        jal_sel,
    output logic        j_sel,
    output logic [1:0]  reg_sel,
    output logic [3:0]  ext_sel,
    output logic [1:0]  alu_src,
    output logic [3:0]  alu_sel,
    output logic        width,
    output logic        illegal,
    output logic        bus_err
);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    logic [31:0]      ir;
    sel_t             sel_q;
    logic             jal_q, ld_q, st_q, br_q, wb_q;
    logic             d_j, d_w, d_ill, d_ld, d_st, d_br, d_wb;
    logic [1:0]       d_rs, d_src;
    logic [3:0]       d_ext, d_alu;

    ctrl_decode_tbl u_dec (
        .instr    (ir),
        .j_sel    (d_j),
        .reg_sel  (d_rs),
        .ext_sel  (d_ext),
        .alu_src  (d_src),
        .alu_sel  (d_alu),
        .width    (d_w),
        .illegal  (d_ill),
        .is_load  (d_ld),
        .is_store (d_st),
        .is_br    (d_br),
        .is_wb    (d_wb)
    );

    assign timeout = (cnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_FETCH:  if (if_ack) state_d = S_DECODE;
            S_DECODE: state_d = d_ill ? S_FETCH : S_EXEC;
            S_EXEC: begin
                if (ld_q || st_q) state_d = S_MEM;
                else if (wb_q)    state_d = S_WB;
                else              state_d = S_FETCH;
            end
            // ack in the timeout cycle still completes the access
            S_MEM: begin
                if (dm_ack)       state_d = st_q ? S_FETCH : S_WB;
                else if (timeout) state_d = S_FETCH;
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // wait counter: cleared on any state change and on a fetch timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state_d != state || timeout)
            cnt <= '0;
        else if (state == S_FETCH || state == S_MEM)
            cnt <= cnt + CNT_W'(1);
        else
            cnt <= '0;
    end

    // private IR copy; instr is only valid in the ack cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         ir <= '0;
        else if (state == S_FETCH && if_ack) ir <= instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            jal_q <= 1'b0;
            ld_q  <= 1'b0;
            st_q  <= 1'b0;
            br_q  <= 1'b0;
            wb_q  <= 1'b0;
        end else if (state == S_DECODE) begin
            sel_q <= d_ill ? '0 : {d_j, d_rs, d_ext, d_src, d_alu, d_w};
            jal_q <= 1'b0;
            ld_q  <= d_ld;
            st_q  <= d_st;
            br_q  <= d_br;
            wb_q  <= d_wb;
        end else if (state == S_EXEC && br_q) begin
            jal_q <= br_taken;
        end
    end

    // branch decision is live during EXEC, then held
    assign jal_sel = (state == S_EXEC && br_q) ? br_taken : jal_q;
    assign j_sel   = sel_q.j_sel;
    assign reg_sel = sel_q.reg_sel;
    assign ext_sel = sel_q.ext_sel;
    assign alu_src = sel_q.alu_src;
    assign alu_sel = sel_q.alu_sel;
    assign width   = sel_q.width;

    // rst_n gating keeps the FETCH request low while reset is held
    always_comb begin
        if_req  = 1'b0;
        ir_we   = 1'b0;
        dm_req  = 1'b0;
        ws_en   = 1'b0;
        w_en    = 1'b0;
        pc_we   = 1'b0;
        illegal = 1'b0;
        bus_err = 1'b0;
        if (rst_n) begin
            unique case (state)
                S_FETCH: begin
                    if_req  = 1'b1;
                    ir_we   = if_ack;
                    bus_err = !if_ack && timeout;
                end
                S_DECODE: begin
                    illegal = d_ill;
                    pc_we   = d_ill;
                end
                S_EXEC:   pc_we = br_q;
                S_MEM: begin
                    dm_req  = 1'b1;
                    ws_en   = st_q;
                    pc_we   = dm_ack ? st_q : timeout;
                    bus_err = !dm_ack && timeout;
                end
                S_WB: begin
                    w_en  = 1'b1;
                    pc_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Randomized bench for ctrl_unit_mc driven from a mnemonic table.
// Expected strobes/selects come from per-class phase sequences.
module tb_ctrl_unit_mc;

    localparam int K_WB  = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_BR  = 3;
    localparam int K_ILL = 4;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] SS = 7'b0100011;
    localparam logic [6:0] BB = 7'b1100011;
    localparam logic [6:0] JR = 7'b1100111;
    localparam logic [6:0] JJ = 7'b1101111;
    localparam logic [6:0] LU = 7'b0110111;
    localparam logic [6:0] AL = 7'b0100000;

    typedef struct {
        string       nm;
        logic [6:0]  op;
        bit          hf3;
        logic [2:0]  f3;
        bit          hf7;
        logic [6:0]  f7;
        int          kind;
        logic [13:0] sel;
    } ent_t;

    logic        clk, rst_n, if_ack, dm_ack, br_taken;
    logic [31:0] instr;
    logic        if_req, ir_we, dm_req, ws_en, w_en, pc_we;
    logic        jal_sel, j_sel, width, illegal, bus_err;
    logic [1:0]  reg_sel, alu_src;
    logic [3:0]  ext_sel, alu_sel;
    logic [7:0]  strb;
    logic [14:0] selo;

    ent_t        tbl[$];
    logic [14:0] held;
    logic [31:0] cur_ins;
    int          n_cmp;
    int          n_err;

    ctrl_unit_mc dut (
        .clk(clk), .rst_n(rst_n), .if_ack(if_ack), .instr(instr),
        .dm_ack(dm_ack), .br_taken(br_taken), .if_req(if_req),
        .ir_we(ir_we), .dm_req(dm_req), .ws_en(ws_en), .w_en(w_en),
        .pc_we(pc_we), .jal_sel(jal_sel), .j_sel(j_sel),
        .reg_sel(reg_sel), .ext_sel(ext_sel), .alu_src(alu_src),
        .alu_sel(alu_sel), .width(width), .illegal(illegal),
        .bus_err(bus_err)
    );

    assign strb = {if_req, ir_we, dm_req, ws_en, w_en, pc_we, illegal, bus_err};
    assign selo = {jal_sel, j_sel, reg_sel, ext_sel, alu_src, alu_sel, width};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] st(input bit a, b, c, d, e, f, g, h);
        return {a, b, c, d, e, f, g, h};
    endfunction

    task automatic add(input string nm, input logic [6:0] op,
                       input bit hf3, input logic [2:0] f3,
                       input bit hf7, input logic [6:0] f7, input int kind,
                       input logic j, input logic [1:0] rs,
                       input logic [3:0] ext, input logic [1:0] src,
                       input logic [3:0] alu, input logic w);
        ent_t e;
        e.nm = nm; e.op = op; e.hf3 = hf3; e.f3 = f3;
        e.hf7 = hf7; e.f7 = f7; e.kind = kind;
        e.sel = {j, rs, ext, src, alu, w};
        tbl.push_back(e);
    endtask

    function automatic int find(input string nm);
        foreach (tbl[i]) if (tbl[i].nm == nm) return i;
        return 0;
    endfunction

    function automatic logic [31:0] enc(input ent_t e);
        logic [31:0] v;
        v = $urandom;
        v[6:0] = e.op;
        if (e.hf3) v[14:12] = e.f3;
        if (e.hf7) v[31:25] = e.f7;
        return v;
    endfunction

    // one clock: drive, check at the falling edge, step past the rising edge
    task automatic cyc(input bit ia, input bit da, input bit bt,
                       input logic [7:0] es, input logic [14:0] ess,
                       input string tag);
        if_ack   = ia;
        dm_ack   = da;
        br_taken = bt;
        instr    = ia ? cur_ins : $urandom;
        @(negedge clk);
        chk({tag, "_strb"}, 32'(strb), 32'(es));
        chk({tag, "_sel"}, 32'(selo), 32'(ess));
        @(posedge clk);
        #1;
    endtask

    // wdm: MEM cycles before dm_ack (>16 means never)
    task automatic run(input ent_t e, input logic [31:0] ins,
                       input int wif, input int wdm, input bit br);
        bit ack, to, done, isst;
        isst    = (e.kind == K_ST);
        cur_ins = ins;
        for (int k = 0; k <= wif; k++)
            cyc(k == wif, rb(), rb(), st(1, k == wif, 0, 0, 0, 0, 0, 0),
                held, {e.nm, "_fetch"});
        if (e.kind == K_ILL) begin
            cyc(rb(), rb(), rb(), st(0, 0, 0, 0, 0, 1, 1, 0), held,
                {e.nm, "_dec"});
            held = '0;
            return;
        end
        cyc(rb(), rb(), rb(), 8'h00, held, {e.nm, "_dec"});
        held = {1'b0, e.sel};
        if (e.kind == K_BR) begin
            held[14] = br;
            cyc(rb(), rb(), br, st(0, 0, 0, 0, 0, 1, 0, 0), held,
                {e.nm, "_exec"});
            return;
        end
        cyc(rb(), rb(), rb(), 8'h00, held, {e.nm, "_exec"});
        to = 1'b0;
        if (e.kind == K_LD || isst) begin
            done = 1'b0;
            for (int k = 0; k <= 16 && !done; k++) begin
                ack  = (k == wdm);
                to   = (k == 16) && !ack;
                done = ack || to;
                cyc(rb(), ack, rb(),
                    st(0, 0, 1, isst, 0, (ack && isst) || to, 0, to),
                    held, {e.nm, "_mem"});
            end
            if (to || isst) return;
        end
        cyc(rb(), rb(), rb(), st(0, 0, 0, 0, 1, 1, 0, 0), held,
            {e.nm, "_wb"});
    endtask

    initial begin
        ent_t e;
        int   wif, wdm, r;
        n_cmp = 0;
        n_err = 0;
        add("add",  R, 1, 3'b000, 1, 7'h00, K_WB, 0, 2'b10, 4'd0, 2'b00, 4'd0, 0);
        add("sub",  R, 1, 3'b000, 1, AL,    K_WB, 0, 2'b10, 4'd0, 2'b00, 4'd1, 0);
        add("and",  R, 1, 3'b111, 1, 7'h00, K_WB, 0, 2'b10, 4'd0, 2'b00, 4'd2, 0);
        add("xor",  R, 1, 3'b100, 1, 7'h00, K_WB, 0, 2'b10, 4'd0, 2'b00, 4'd3, 0);
        add("or",   R, 1, 3'b110, 1, 7'h00, K_WB, 0, 2'b10, 4'd0, 2'b00, 4'd9, 0);
        add("sll",  R, 1, 3'b001, 1, 7'h00, K_WB, 0, 2'b10, 4'd0, 2'b00, 4'd5, 0);
        add("srl",  R, 1, 3'b101, 1, 7'h00, K_WB, 0, 2'b10, 4'd0, 2'b00, 4'd6, 0);
        add("sra",  R, 1, 3'b101, 1, AL,    K_WB, 0, 2'b10, 4'd0, 2'b00, 4'd4, 0);
        add("addi", I, 1, 3'b000, 0, 7'h00, K_WB, 0, 2'b10, 4'd1, 2'b01, 4'd0, 0);
        add("xori", I, 1, 3'b100, 0, 7'h00, K_WB, 0, 2'b10, 4'd1, 2'b01, 4'd3, 0);
        add("andi", I, 1, 3'b111, 0, 7'h00, K_WB, 0, 2'b10, 4'd1, 2'b01, 4'd2, 0);
        add("ori",  I, 1, 3'b110, 0, 7'h00, K_WB, 0, 2'b10, 4'd1, 2'b01, 4'd9, 0);
        add("slli", I, 1, 3'b001, 1, 7'h00, K_WB, 0, 2'b10, 4'd1, 2'b01, 4'd5, 0);
        add("srli", I, 1, 3'b101, 1, 7'h00, K_WB, 0, 2'b10, 4'd1, 2'b01, 4'd6, 0);
        add("srai", I, 1, 3'b101, 1, AL,    K_WB, 0, 2'b10, 4'd1, 2'b01, 4'd4, 0);
        add("lw",   LD, 1, 3'b010, 0, 7'h00, K_LD, 0, 2'b01, 4'd1, 2'b01, 4'd0, 0);
        add("lbu",  LD, 1, 3'b100, 0, 7'h00, K_LD, 0, 2'b01, 4'd1, 2'b01, 4'd0, 1);
        add("sw",   SS, 1, 3'b010, 0, 7'h00, K_ST, 0, 2'b00, 4'd2, 2'b01, 4'd0, 0);
        add("sb",   SS, 1, 3'b000, 0, 7'h00, K_ST, 0, 2'b00, 4'd2, 2'b01, 4'd0, 1);
        add("bne",  BB, 1, 3'b001, 0, 7'h00, K_BR, 0, 2'b00, 4'd3, 2'b00, 4'd7, 0);
        add("jal",  JJ, 0, 3'b000, 0, 7'h00, K_WB, 1, 2'b11, 4'd4, 2'b10, 4'd0, 0);
        add("jalr", JR, 1, 3'b000, 0, 7'h00, K_WB, 1, 2'b11, 4'd1, 2'b01, 4'd0, 0);
        add("lui",  LU, 0, 3'b000, 0, 7'h00, K_WB, 0, 2'b10, 4'd5, 2'b01, 4'd8, 0);
        add("srai_bad", I, 1, 3'b101, 1, 7'h01, K_ILL, 0, 0, 0, 0, 0, 0);
        add("add_bad",  R, 1, 3'b000, 1, 7'h01, K_ILL, 0, 0, 0, 0, 0, 0);
        add("slt",      R, 1, 3'b010, 1, 7'h00, K_ILL, 0, 0, 0, 0, 0, 0);
        add("slti",     I, 1, 3'b011, 0, 7'h00, K_ILL, 0, 0, 0, 0, 0, 0);
        add("slli_bad", I, 1, 3'b001, 1, AL,    K_ILL, 0, 0, 0, 0, 0, 0);
        add("lb",       LD, 1, 3'b000, 0, 7'h00, K_ILL, 0, 0, 0, 0, 0, 0);
        add("sh",       SS, 1, 3'b001, 0, 7'h00, K_ILL, 0, 0, 0, 0, 0, 0);
        add("beq",      BB, 1, 3'b000, 0, 7'h00, K_ILL, 0, 0, 0, 0, 0, 0);
        add("jalr_bad", JR, 1, 3'b001, 0, 7'h00, K_ILL, 0, 0, 0, 0, 0, 0);
        add("auipc",    7'b0010111, 0, 3'b000, 0, 7'h00, K_ILL, 0, 0, 0, 0, 0, 0);
        add("zero_op",  7'b0000000, 0, 3'b000, 0, 7'h00, K_ILL, 0, 0, 0, 0, 0, 0);

        rst_n    = 1'b0;
        if_ack   = 1'b0;
        dm_ack   = 1'b0;
        br_taken = 1'b0;
        instr    = '0;
        held     = '0;
        #3;
        chk("reset_strb", 32'(strb), 32'h0);
        chk("reset_sel", 32'(selo), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run(tbl[find("add")], 32'h002081B3, 0, 0, 0);
        e = tbl[find("srai")];     run(e, enc(e), 1, 0, 1);
        e = tbl[find("srai_bad")]; run(e, enc(e), 0, 0, 0);
        e = tbl[find("sw")];       run(e, enc(e), 2, 3, 0);
        e = tbl[find("lbu")];      run(e, enc(e), 0, 99, 0);
        e = tbl[find("bne")];      run(e, enc(e), 0, 0, 1);
        e = tbl[find("bne")];      run(e, enc(e), 0, 0, 0);
        e = tbl[find("lw")];       run(e, enc(e), 0, 16, 0);
        e = tbl[find("jal")];      run(e, enc(e), 3, 0, 0);

        cur_ins = $urandom;
        repeat (2)
            for (int k = 0; k <= 16; k++)
                cyc(0, rb(), rb(), st(1, 0, 0, 0, 0, 0, 0, k == 16), held,
                    "fetch_tmo");
        e = tbl[find("addi")];     run(e, enc(e), 16, 0, 0);

        e = tbl[find("sw")];
        cur_ins = enc(e);
        cyc(1, 0, 0, st(1, 1, 0, 0, 0, 0, 0, 0), held, "rst_fetch");
        cyc(0, 0, 0, 8'h00, held, "rst_dec");
        held = {1'b0, e.sel};
        cyc(0, 0, 0, 8'h00, held, "rst_exec");
        cyc(0, 0, 0, st(0, 0, 1, 1, 0, 0, 0, 0), held, "rst_mem");
        dm_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_strb", 32'(strb), 32'h0);
        chk("rst_async_sel", 32'(selo), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_strb", 32'(strb), 32'h0);
        rst_n = 1'b1;
        held  = '0;
        e = tbl[find("lui")];      run(e, enc(e), 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            e   = tbl[$urandom_range(0, tbl.size() - 1)];
            wif = $urandom_range(0, 3);
            r   = $urandom_range(0, 9);
            wdm = (r == 0) ? 16 : (r == 1) ? 99 : $urandom_range(0, 4);
            run(e, enc(e), wif, wdm, rb());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
